// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage in front of the 32x32 register file.
// Holds one MIPS-I instruction, decodes it, issues register-file reads once
// its sources are free of pending writers, then presents the operand bundle
// to execute. A per-register pending-write scoreboard tracks in-flight writers.
module id_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter bit          SB_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch side
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    // register file read ports
    output logic [REG_AW-1:0] rf_read_reg1,
    output logic              rf_read_en1,
    output logic [REG_AW-1:0] rf_read_reg2,
    output logic              rf_read_en2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    // writeback snoop
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_reg,
    // pipeline control
    input  logic              flush,
    // execute side
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_illegal
);

    localparam int unsigned NREG  = 1 << REG_AW;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_READ  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc_q;
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_d;

    // instruction fields of the held instruction
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_jump;

    // decode results
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] imm;
    logic              illegal;

    // hazard detection
    logic              pend_rs;
    logic              pend_rt;
    logic              hazard;

    // FSM strobes
    logic              accept;
    logic              capture;
    logic              issue;

    assign op       = instr_q[31:26];
    assign rs       = REG_AW'(instr_q[25:21]);
    assign rt       = REG_AW'(instr_q[20:16]);
    assign rd       = REG_AW'(instr_q[15:11]);
    assign imm16    = instr_q[15:0];
    assign imm_sext = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm16};
    assign imm_jump = {pc_q[DATA_W-1 -: 4], instr_q[25:0], 2'b00};

    assign rf_read_reg1 = rs;
    assign rf_read_reg2 = rt;

    // Opcode decode: source usage, destination, immediate form.
    // R-type and illegal opcodes carry no immediate (ex_imm = 0).
    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        dest    = '0;
        imm     = '0;
        illegal = 1'b0;
        case (op)
            6'h00: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dest   = rd;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                use_rs = 1'b1;
                dest   = rt;
                imm    = imm_sext;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                use_rs = 1'b1;
                dest   = rt;
                imm    = imm_zext;
            end
            6'h0F: begin
                dest = rt;
                imm  = imm_zext << IMM_W;
            end
            6'h23: begin
                use_rs = 1'b1;
                dest   = rt;
                imm    = imm_sext;
            end
            6'h2B: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                imm    = imm_sext;
            end
            6'h04, 6'h05: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                imm    = imm_sext << 2;
            end
            6'h02: begin
                imm = imm_jump;
            end
            6'h03: begin
                imm  = imm_jump;
                dest = REG_AW'(31);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // A source is pending unless it is $0 or its writer retires this cycle
    // (the regfile writes on negedge, so the posedge read sees the new value).
    assign pend_rs = sb_q[rs] && !(wb_valid && (wb_reg == rs)) && (rs != '0);
    assign pend_rt = sb_q[rt] && !(wb_valid && (wb_reg == rt)) && (rt != '0);
    assign hazard  = SB_EN && ((use_rs && pend_rs) || (use_rt && pend_rt));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (if_valid) state_d = S_CHECK;
                S_CHECK: if (!hazard)  state_d = S_READ;
                S_READ:  state_d = S_OUT;
                S_OUT:   if (ex_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Handshake, read-enable and datapath strobes decoded from state.
    always_comb begin
        if_ready    = 1'b0;
        rf_read_en1 = 1'b0;
        rf_read_en2 = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        issue       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if_ready = 1'b1;
                    accept   = if_valid && !flush;
                end
                S_CHECK: begin
                    if (!hazard && !flush) begin
                        rf_read_en1 = use_rs;
                        rf_read_en2 = use_rt;
                    end
                end
                S_READ: begin
                    capture = !flush;
                end
                S_OUT: begin
                    issue = ex_ready && !flush;
                end
                default: ;
            endcase
        end
    end

    // Latch the accepted instruction and its pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            instr_q <= if_instr;
            pc_q    <= if_pc;
        end
    end

    // Capture the operand bundle when the register-file data arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_opcode  <= '0;
            ex_funct   <= '0;
            ex_rs_val  <= '0;
            ex_rt_val  <= '0;
            ex_imm     <= '0;
            ex_dest    <= '0;
            ex_pc      <= '0;
            ex_illegal <= 1'b0;
        end else if (capture) begin
            ex_opcode  <= op;
            ex_funct   <= instr_q[5:0];
            ex_rs_val  <= use_rs ? rf_read_data1 : '0;
            ex_rt_val  <= use_rt ? rf_read_data2 : '0;
            ex_imm     <= imm;
            ex_dest    <= dest;
            ex_pc      <= pc_q;
            ex_illegal <= illegal;
        end
    end

    // Bundle valid: raised on capture, dropped on hand-off or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (capture) begin
            ex_valid <= 1'b1;
        end else if (issue) begin
            ex_valid <= 1'b0;
        end
    end

    // Scoreboard update: writeback clears first, issue sets last so it wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_reg] = 1'b0;
        end
        if (issue && (ex_dest != '0)) begin
            sb_d[ex_dest] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule
